// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Contents: fetch_entry_t {pc, instr}, NOP_INSTR encoding, PC_STEP increment.
// No ports; imported by fetch_fifo and fetch_buffered.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_STEP   = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for fetched {pc, instr} entries.
// Ports: clk, reset (async active-low), push/wdata, pop/rdata (head, valid when !empty),
//        clear (drops all entries), full, empty, count.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  entry_t                 wdata,
  input  logic                   pop,
  input  logic                   clear,
  output entry_t                 rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t          mem [DEPTH];
  logic   [AW-1:0] rd_ptr;
  logic   [AW-1:0] wr_ptr;
  logic            do_pop;

  // DEPTH is a power of two, so the pointers wrap naturally.
  assign do_pop = pop && !empty;
  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign rdata  = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only observed once written.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_buffered.sv
// Instruction-fetch stage with prefetch FIFO, multiple outstanding requests and
// branch-redirect flush. Optional macro FETCH_BYPASS_EN adds a same-cycle path
// from memory response to decode when the FIFO is empty.
// Ports: req (clock), reset (async active-low); memory side instr_req_out/instr_addr_out/
//        gnt_in/instr_rvalid_in/instr_rdata_in; branch_mispredicted_in/branch_target_in;
//        decode side stall_in/valid_out/instr_out/pc_out.
module fetch_buffered
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            req,
  input  logic            reset,
  output logic            instr_req_out,
  output logic [XLEN-1:0] instr_addr_out,
  input  logic            gnt_in,
  input  logic            instr_rvalid_in,
  input  logic [XLEN-1:0] instr_rdata_in,
  input  logic            branch_mispredicted_in,
  input  logic [XLEN-1:0] branch_target_in,
  input  logic            stall_in,
  output logic            valid_out,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out
);

  localparam int              CW   = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic            started;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;

  logic            grant;
  logic            flush;
  logic            resp_keep;
  logic            bypass_hit;
  logic            bypass_take;
  logic            push;
  logic            pop;
  logic [CW:0]     credit_used;
  logic [CW-1:0]   outstanding_next;
  logic [XLEN-1:0] target;

  entry_t          push_entry;
  entry_t          head;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;

  // Requests are held off for the first cycle after reset release.
  assign credit_used    = {1'b0, outstanding} + {1'b0, fifo_count};
  assign instr_req_out  = started && (credit_used < (CW+1)'(DEPTH));
  assign instr_addr_out = fetch_pc;

  assign grant     = instr_req_out && gnt_in;
  assign flush     = branch_mispredicted_in;
  assign target    = {branch_target_in[XLEN-1:2], 2'b00};
  // A response is kept only if it is not owed to a pre-flush request and
  // does not coincide with a flush.
  assign resp_keep = instr_rvalid_in && (discard == '0) && !flush;

`ifdef FETCH_BYPASS_EN
  assign bypass_hit = fifo_empty && resp_keep;
`else
  assign bypass_hit = 1'b0;
`endif

  assign bypass_take = bypass_hit && !stall_in;
  assign push        = resp_keep && !bypass_take;
  assign pop         = !fifo_empty && !stall_in && !flush;
  assign valid_out   = !fifo_empty || bypass_hit;

  assign push_entry.pc    = resp_pc;
  assign push_entry.instr = instr_rdata_in;

  always_comb begin
    instr_out = '0;
    pc_out    = resp_pc;
    if (!fifo_empty) begin
      instr_out = head.instr;
      pc_out    = head.pc;
    end else if (bypass_hit) begin
      instr_out = instr_rdata_in;
      pc_out    = resp_pc;
    end
  end

  assign outstanding_next = outstanding + CW'(grant) - CW'(instr_rvalid_in);

  always_ff @(posedge req or negedge reset) begin
    if (!reset) begin
      started     <= 1'b0;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      started     <= 1'b1;
      outstanding <= outstanding_next;
      if (flush) begin
        fetch_pc <= target;
        resp_pc  <= target;
        // Every request still owed a response (including one granted now,
        // minus one answered now) must have its data dropped.
        discard  <= outstanding_next;
      end else begin
        if (grant)     fetch_pc <= fetch_pc + STEP;
        if (resp_keep) resp_pc  <= resp_pc + STEP;
        if (instr_rvalid_in && (discard != '0)) discard <= discard - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (req),
    .reset (reset),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .clear (flush),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Credit accounting guarantees a free slot for every response.
  always @(posedge req) begin
    if (reset) assert (!(push && fifo_full));
  end

endmodule

// File: tb/tb_fetch_buffered.sv
// Directed self-checking bench for fetch_buffered (DEPTH=4, RESET_PC=0).
// Inputs change at the falling edge, outputs are compared 1 time unit later.
// Each test starts from reset; cycle 0 is the first cycle with requests enabled.
module tb_fetch_buffered;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_req_out;
  logic [31:0] instr_addr_out;
  logic        gnt_in = 1'b0;
  logic        instr_rvalid_in = 1'b0;
  logic [31:0] instr_rdata_in = '0;
  logic        branch_mispredicted_in = 1'b0;
  logic [31:0] branch_target_in = '0;
  logic        stall_in = 1'b0;
  logic        valid_out;
  logic [31:0] instr_out;
  logic [31:0] pc_out;

  int checks = 0;
  int errors = 0;

`ifdef FETCH_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  fetch_buffered #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .req                    (clk),
    .reset                  (rst_n),
    .instr_req_out          (instr_req_out),
    .instr_addr_out         (instr_addr_out),
    .gnt_in                 (gnt_in),
    .instr_rvalid_in        (instr_rvalid_in),
    .instr_rdata_in         (instr_rdata_in),
    .branch_mispredicted_in (branch_mispredicted_in),
    .branch_target_in       (branch_target_in),
    .stall_in               (stall_in),
    .valid_out              (valid_out),
    .instr_out              (instr_out),
    .pc_out                 (pc_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                       input logic st, input logic mp, input logic [31:0] tgt);
    @(negedge clk);
    gnt_in = g; instr_rvalid_in = rv; instr_rdata_in = rd;
    stall_in = st; branch_mispredicted_in = mp; branch_target_in = tgt;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    gnt_in = 0; instr_rvalid_in = 0; instr_rdata_in = '0;
    stall_in = 0; branch_mispredicted_in = 0; branch_target_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (instr_req_out !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", instr_req_out); end
    checks++; if (instr_addr_out !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", instr_addr_out); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_out); end
    checks++; if (instr_out !== 32'h0 || pc_out !== 32'h0) begin errors++; $display("FAIL reset_out instr %h pc %h exp 0 0", instr_out, pc_out); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] ep;
    test_reset();
    for (int c = 0; c < 8; c++) begin
      drive(1, c >= 1, dat(32'(4*(c-1))), 0, 0, 0);
      checks++;
      if (instr_req_out !== 1'b1 || instr_addr_out !== 32'(4*c)) begin
        errors++; $display("FAIL stream_req c=%0d got %b/%h exp 1/%h", c, instr_req_out, instr_addr_out, 32'(4*c));
      end
      checks++;
      if (valid_out !== (c >= 1 + LAT)) begin
        errors++; $display("FAIL stream_valid c=%0d got %b exp %b", c, valid_out, (c >= 1 + LAT));
      end
      if (c >= 1 + LAT) begin
        ep = 32'(4*(c-1-LAT));
        checks++;
        if (pc_out !== ep || instr_out !== dat(ep)) begin
          errors++; $display("FAIL stream_data c=%0d got %h/%h exp %h/%h", c, pc_out, instr_out, ep, dat(ep));
        end
      end
    end
  endtask

  task automatic test_stall();
    logic        er;
    logic [31:0] ea;
    test_reset();
    for (int c = 0; c < 7; c++) begin
      drive(1, (c >= 1 && c <= 4), dat(32'(4*(c-1))), 1, 0, 0);
      er = (c <= 3);
      ea = (c <= 3) ? 32'(4*c) : 32'h10;
      checks++;
      if (instr_req_out !== er || instr_addr_out !== ea) begin
        errors++; $display("FAIL stall_req c=%0d got %b/%h exp %b/%h", c, instr_req_out, instr_addr_out, er, ea);
      end
      if (c >= 2) begin
        checks++;
        if (valid_out !== 1'b1 || pc_out !== 32'h0) begin
          errors++; $display("FAIL stall_head c=%0d got %b/%h exp 1/0", c, valid_out, pc_out);
        end
      end
    end
    drive(1, 0, 0, 0, 0, 0);
    checks++;
    if (instr_req_out !== 1'b0 || valid_out !== 1'b1 || pc_out !== 32'h0) begin
      errors++; $display("FAIL stall_release got req %b valid %b pc %h exp 0 1 0", instr_req_out, valid_out, pc_out);
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (instr_req_out !== 1'b1 || instr_addr_out !== 32'h10) begin
      errors++; $display("FAIL stall_resume got %b/%h exp 1/00000010", instr_req_out, instr_addr_out);
    end
    checks++;
    if (pc_out !== 32'h4 || instr_out !== dat(32'h4)) begin
      errors++; $display("FAIL stall_next got %h/%h exp 4/%h", pc_out, instr_out, dat(32'h4));
    end
  endtask

  task automatic test_gnt_wait();
    test_reset();
    for (int c = 0; c < 4; c++) begin
      drive(c == 3, 0, 0, 0, 0, 0);
      checks++;
      if (instr_req_out !== 1'b1 || instr_addr_out !== 32'h0) begin
        errors++; $display("FAIL gntwait_hold c=%0d got %b/%h exp 1/0", c, instr_req_out, instr_addr_out);
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (instr_req_out !== 1'b1 || instr_addr_out !== 32'h4 || valid_out !== 1'b0) begin
      errors++; $display("FAIL gntwait_adv got %b/%h/%b exp 1/4/0", instr_req_out, instr_addr_out, valid_out);
    end
  endtask

  task automatic test_flush();
    test_reset();
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 32'h0000_0103);
    checks++;
    if (instr_addr_out !== 32'h8) begin errors++; $display("FAIL flush_preaddr got %h exp 8", instr_addr_out); end
    drive(0, 1, dat(32'h0), 0, 0, 0);
    checks++;
    if (instr_req_out !== 1'b1 || instr_addr_out !== 32'h100 || valid_out !== 1'b0) begin
      errors++; $display("FAIL flush_redirect got %b/%h/%b exp 1/100/0", instr_req_out, instr_addr_out, valid_out);
    end
    drive(1, 1, dat(32'h4), 0, 0, 0);
    checks++;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL flush_drop2 got %b exp 0", valid_out); end
    drive(0, 1, dat(32'h100), 0, 0, 0);
    checks++;
    if (instr_addr_out !== 32'h104 || valid_out !== (LAT == 0)) begin
      errors++; $display("FAIL flush_resp got %h/%b exp 104/%b", instr_addr_out, valid_out, (LAT == 0));
    end
    if (LAT == 0) begin
      checks++;
      if (pc_out !== 32'h100 || instr_out !== dat(32'h100)) begin
        errors++; $display("FAIL flush_first got %h/%h exp 100/%h", pc_out, instr_out, dat(32'h100));
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (valid_out !== (LAT == 1)) begin errors++; $display("FAIL flush_valid got %b exp %b", valid_out, (LAT == 1)); end
    if (LAT == 1) begin
      checks++;
      if (pc_out !== 32'h100 || instr_out !== dat(32'h100)) begin
        errors++; $display("FAIL flush_first got %h/%h exp 100/%h", pc_out, instr_out, dat(32'h100));
      end
    end
  endtask

  task automatic test_flush_same_cycle();
    test_reset();
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, dat(32'h0), 0, 1, 32'h0000_0202);
    checks++;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL fsame_flushcyc got %b exp 0", valid_out); end
    drive(1, 1, dat(32'h4), 0, 0, 0);
    checks++;
    if (instr_req_out !== 1'b1 || instr_addr_out !== 32'h200 || valid_out !== 1'b0) begin
      errors++; $display("FAIL fsame_discard got %b/%h/%b exp 1/200/0", instr_req_out, instr_addr_out, valid_out);
    end
    drive(0, 1, dat(32'h200), 0, 0, 0);
    checks++;
    if (valid_out !== (LAT == 0)) begin errors++; $display("FAIL fsame_resp got %b exp %b", valid_out, (LAT == 0)); end
    drive(0, 0, 0, 0, 0, 0);
    if (LAT == 1) begin
      checks++;
      if (valid_out !== 1'b1 || pc_out !== 32'h200 || instr_out !== dat(32'h200)) begin
        errors++; $display("FAIL fsame_first got %b/%h/%h exp 1/200/%h", valid_out, pc_out, instr_out, dat(32'h200));
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL fsame_nostale got %b/%h exp 0", valid_out, instr_out); end
  endtask

  task automatic test_mid_reset();
    test_reset();
    for (int c = 0; c < 3; c++) drive(1, c >= 1, dat(32'(4*(c-1))), 0, 0, 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (instr_req_out !== 1'b0 || instr_addr_out !== 32'h0) begin
      errors++; $display("FAIL midreset_req got %b/%h exp 0/0", instr_req_out, instr_addr_out);
    end
    checks++;
    if (valid_out !== 1'b0 || instr_out !== 32'h0 || pc_out !== 32'h0) begin
      errors++; $display("FAIL midreset_out got %b/%h/%h exp 0/0/0", valid_out, instr_out, pc_out);
    end
  endtask

`ifdef FETCH_BYPASS_EN
  task automatic test_bypass();
    test_reset();
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, dat(32'h0), 0, 0, 0);
    checks++;
    if (valid_out !== 1'b1 || pc_out !== 32'h0 || instr_out !== dat(32'h0)) begin
      errors++; $display("FAIL bypass_same got %b/%h/%h exp 1/0/%h", valid_out, pc_out, instr_out, dat(32'h0));
    end
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL bypass_nopush got %b exp 0", valid_out); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_gnt_wait();
    test_flush();
    test_flush_same_cycle();
`ifdef FETCH_BYPASS_EN
    test_bypass();
`endif
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
